// File: rtl/scu_dma_arbiter.sv
// Shared-bus arbiter for the three SCU DMA levels and the DSP DMA port.
// Grants one owner at a time, forwards word acks, signals end of transfer and preempts long bursts.
module scu_dma_arbiter #(
  parameter int MAX_BURST  = 8,
  parameter int DSP_HIGH   = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [3:0] REQ,
  input  logic [3:0] LAST,
  output logic [3:0] ACK,
  output logic [3:0] END,
  output logic [1:0] OWNER,
  output logic       OWNER_VLD,
  output logic       BUS_REQ,
  input  logic       BUS_ACK
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE,
    GAP
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [3:0] GAP_LAST    = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam state_t     AFTER_OWN   = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t     state;
  logic [7:0] burst;
  logic [3:0] gap_cnt;
  logic [3:0] mask;

  logic [3:0] masked_req;
  logic [3:0] eligible;
  logic [1:0] winner;
  logic [7:0] burst_next;
  logic [3:0] owner_onehot;

  // A preempted owner is skipped once, but only if someone else is waiting.
  always_comb begin
    masked_req = REQ & ~mask;
    eligible   = (masked_req != 4'd0) ? masked_req : REQ;
    winner     = 2'd0;
    if ((DSP_HIGH != 0) && eligible[3]) begin
      winner = 2'd3;
    end else if (eligible[0]) begin
      winner = 2'd0;
    end else if (eligible[1]) begin
      winner = 2'd1;
    end else if (eligible[2]) begin
      winner = 2'd2;
    end else if (eligible[3]) begin
      winner = 2'd3;
    end
  end

  assign burst_next   = burst + 8'd1;
  assign owner_onehot = 4'b0001 << OWNER;

  // ACK/END are one-CLK pulses independent of CE; everything else advances only on CE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ACK       <= 4'd0;
      END       <= 4'd0;
      OWNER     <= 2'd0;
      OWNER_VLD <= 1'b0;
      BUS_REQ   <= 1'b0;
      burst     <= 8'd0;
      gap_cnt   <= 4'd0;
      mask      <= 4'd0;
    end else begin
      ACK <= 4'd0;
      END <= 4'd0;
      if (CE) begin
        case (state)
          IDLE: begin
            if (REQ != 4'd0) begin
              OWNER     <= winner;
              OWNER_VLD <= 1'b1;
              BUS_REQ   <= 1'b1;
              burst     <= 8'd0;
              mask      <= 4'd0;
              state     <= XFER;
            end
          end
          XFER: begin
            if (BUS_ACK) begin
              ACK   <= owner_onehot;
              burst <= burst_next;
              if (LAST[OWNER]) begin
                BUS_REQ <= 1'b0;
                state   <= DONE;
              end else if (burst_next == BURST_LIMIT) begin
                BUS_REQ   <= 1'b0;
                OWNER_VLD <= 1'b0;
                mask      <= mask | owner_onehot;
                gap_cnt   <= 4'd0;
                state     <= AFTER_OWN;
              end else if (!REQ[OWNER]) begin
                BUS_REQ   <= 1'b0;
                OWNER_VLD <= 1'b0;
                gap_cnt   <= 4'd0;
                state     <= AFTER_OWN;
              end
            end else if (!REQ[OWNER]) begin
              BUS_REQ   <= 1'b0;
              OWNER_VLD <= 1'b0;
              gap_cnt   <= 4'd0;
              state     <= AFTER_OWN;
            end
          end
          DONE: begin
            END       <= owner_onehot;
            OWNER_VLD <= 1'b0;
            gap_cnt   <= 4'd0;
            state     <= AFTER_OWN;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scu_dma_arbiter.sv
// Directed self-checking bench for scu_dma_arbiter; three instances share stimulus
// (defaults, DSP-high priority, and a 4-word burst limit).
module tb_scu_dma_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic [3:0] REQ;
  logic [3:0] LAST;
  logic       BUS_ACK;

  logic [3:0] ack_o   [3];
  logic [3:0] end_o   [3];
  logic [1:0] owner_o [3];
  logic       vld_o   [3];
  logic       breq_o  [3];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  scu_dma_arbiter #(.MAX_BURST(8), .DSP_HIGH(0), .GAP_CYCLES(1)) dut_base (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .LAST(LAST),
    .ACK(ack_o[0]), .END(end_o[0]), .OWNER(owner_o[0]), .OWNER_VLD(vld_o[0]),
    .BUS_REQ(breq_o[0]), .BUS_ACK(BUS_ACK)
  );

  scu_dma_arbiter #(.MAX_BURST(8), .DSP_HIGH(1), .GAP_CYCLES(1)) dut_dsp (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .LAST(LAST),
    .ACK(ack_o[1]), .END(end_o[1]), .OWNER(owner_o[1]), .OWNER_VLD(vld_o[1]),
    .BUS_REQ(breq_o[1]), .BUS_ACK(BUS_ACK)
  );

  scu_dma_arbiter #(.MAX_BURST(4), .DSP_HIGH(0), .GAP_CYCLES(1)) dut_short (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .LAST(LAST),
    .ACK(ack_o[2]), .END(end_o[2]), .OWNER(owner_o[2]), .OWNER_VLD(vld_o[2]),
    .BUS_REQ(breq_o[2]), .BUS_ACK(BUS_ACK)
  );

  task automatic applyStimulus(input logic ce, input logic [3:0] req, input logic [3:0] last,
                               input logic bus_ack);
    CE      = ce;
    REQ     = req;
    LAST    = last;
    BUS_ACK = bus_ack;
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input int d, input string tag, input logic [3:0] ack,
                           input logic [3:0] endp, input logic [1:0] owner,
                           input logic vld, input logic breq);
    checkOutput({tag, ".ack"},   ack_o[d],          ack);
    checkOutput({tag, ".end"},   end_o[d],          endp);
    checkOutput({tag, ".owner"}, {2'b00, owner_o[d]}, {2'b00, owner});
    checkOutput({tag, ".vld"},   {3'b000, vld_o[d]},  {3'b000, vld});
    checkOutput({tag, ".breq"},  {3'b000, breq_o[d]}, {3'b000, breq});
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    for (int d = 0; d < 3; d++) expectOut(d, "reset", 4'b0, 4'b0, 2'd0, 1'b0, 1'b0);

    // Single DSP request, three words, LAST on the third.
    applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b1);
    tick();
    expectOut(0, "dsp.grant", 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1);
    tick();
    expectOut(0, "dsp.w1", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
    tick();
    expectOut(0, "dsp.w2", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b1);
    tick();
    expectOut(0, "dsp.w3", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    expectOut(0, "dsp.end", 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0);
    tick();
    expectOut(0, "dsp.gap", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    expectOut(0, "dsp.idle", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Simultaneous requests under both priority orders.
    doReset();
    applyStimulus(1'b1, 4'b1011, 4'b0000, 1'b0);
    tick();
    expectOut(0, "prio.lowdsp", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    expectOut(1, "prio.highdsp", 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1);

    // Level 2 waits until levels 0 and 1 have finished.
    doReset();
    applyStimulus(1'b1, 4'b0111, 4'b0000, 1'b0);
    tick();
    expectOut(0, "ord.l0", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b1);
    tick();
    expectOut(0, "ord.l0w", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0110, 4'b0000, 1'b0);
    tick();
    expectOut(0, "ord.l0end", 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    expectOut(0, "ord.l1", 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0110, 4'b0010, 1'b1);
    tick();
    expectOut(0, "ord.l1w", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
    tick();
    expectOut(0, "ord.l1end", 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    tick();
    expectOut(0, "ord.l2", 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);

    // Preemption with a 4-word burst limit, L0 and L1 requesting continuously.
    doReset();
    applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b1);
    tick();
    expectOut(2, "pre.g0", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expectOut(2, $sformatf("pre.l0w%0d", i), 4'b0001, 4'b0000, 2'd0, i < 4, i < 4);
    end
    tick();
    expectOut(2, "pre.gap0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expectOut(2, "pre.g1", 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expectOut(2, $sformatf("pre.l1w%0d", i), 4'b0010, 4'b0000, 2'd1, i < 4, i < 4);
    end
    tick();
    tick();
    expectOut(2, "pre.regrant0", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);

    // Bus stall, then CE gating with BUS_ACK and LAST presented while disabled.
    doReset();
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      expectOut(0, $sformatf("stall%0d", i), 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
    tick();
    expectOut(0, "stall.word", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectOut(0, $sformatf("ce0_%0d", i), 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1);
    tick();
    expectOut(0, "ce.last", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    expectOut(0, "ce.end", 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0);

    // Requester drop without and with a word completing in the drop cycle.
    doReset();
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
    tick();
    expectOut(0, "drop.g", 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
    tick();
    expectOut(0, "drop.w", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    expectOut(0, "drop.rel", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    expectOut(0, "drop.gap", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
    tick();
    expectOut(0, "drop2.g", 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick();
    expectOut(0, "drop2.rel", 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    expectOut(0, "drop2.gap", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset after two words, then a full 8-word burst from a fresh count.
    doReset();
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    expectOut(0, "rst.w2", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    expectOut(0, "rst.mid", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expectOut(0, "rst.regrant", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      expectOut(0, $sformatf("rst.w%0d", i), 4'b0001, 4'b0000, 2'd0, i < 8, i < 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
